seq_binary_to_bcd: RTL and testbench

Parametrised, multi-cycle binary-to-BCD converter using iterative double-dabble, one input bit per clock.
- Input: BIN_WIDTH-bit unsigned binary with a valid/ready handshake.
- Output: DIGITS packed BCD digits plus an overflow flag with a valid/ready handshake.
- Replaces single-cycle 8-bit combinational conversion in display and UART-print paths where wide operands would blow timing.

---
 rtl/seq_binary_to_bcd_pkg.sv | 16 +
 rtl/seq_binary_to_bcd_if.sv | 25 ++
 rtl/seq_binary_to_bcd_digit_adjust.sv | 8 +
 rtl/seq_binary_to_bcd.sv | 88 ++++++++
 tb/tb_seq_binary_to_bcd.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/seq_binary_to_bcd_pkg.sv
// rtl/seq_binary_to_bcd_pkg.sv - shared state type and sizing helper for the binary-to-BCD converter
package bcd_pkg;

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      DONE
   } bcd_state_e;

   // Decimal digits needed to hold any width-bit unsigned value: ceil(width * log10(2)).
   // log10(2) is approximated as 0.30103 in fixed point.
   function automatic int min_digits(input int width);
      return (width * 30103 + 99999) / 100000;
   endfunction

endpackage

// File: rtl/seq_binary_to_bcd_if.sv
// rtl/seq_binary_to_bcd_if.sv - operand/result handshake bundle for the binary-to-BCD converter
interface seq_binary_to_bcd_if #(
   parameter int BIN_WIDTH = 8,
   parameter int DIGITS    = 3
);
   logic                    in_valid;
   logic                    in_ready;
   logic [BIN_WIDTH-1:0]    binary_in;
   logic                    out_valid;
   logic                    out_ready;
   logic [4*DIGITS-1:0]     bcd_out;
   logic                    overflow;

   // Producer/consumer side
   modport master (
      output in_valid, binary_in, out_ready,
      input  in_ready, out_valid, bcd_out, overflow
   );

   // Converter side
   modport slave (
      input  in_valid, binary_in, out_ready,
      output in_ready, out_valid, bcd_out, overflow
   );
endinterface

// File: rtl/seq_binary_to_bcd_digit_adjust.sv
// rtl/seq_binary_to_bcd_digit_adjust.sv - double-dabble add-3 correction for one BCD digit
module bcd_digit_adjust (
   input  logic [3:0] digit,
   output logic [3:0] adjusted
);
   // A digit of 5..9 becomes 8..12 so the following left shift carries correctly into the next digit
   assign adjusted = (digit >= 4'd5) ? digit + 4'd3 : digit;
endmodule

// File: rtl/seq_binary_to_bcd.sv
// rtl/seq_binary_to_bcd.sv - iterative double-dabble binary-to-BCD converter, one operand bit per clock
module seq_binary_to_bcd
   import bcd_pkg::*;
#(
   parameter int BIN_WIDTH = 8,
   parameter int DIGITS    = 3
) (
   input  logic                clk,
   input  logic                rst_n,
   seq_binary_to_bcd_if.slave  bus
);

   localparam int CNT_W = $clog2(BIN_WIDTH + 1);
   localparam int BCD_W = 4 * DIGITS;
   // With enough digits the top digit can never shift out a one, so the sticky flag is tied off.
   localparam bit CAN_OVERFLOW = (DIGITS < min_digits(BIN_WIDTH));

   bcd_state_e            state;
   logic [BIN_WIDTH-1:0]  shift_q;
   logic [BCD_W-1:0]      bcd_q;
   logic [BCD_W-1:0]      bcd_adj;
   logic                  overflow_q;
   logic [CNT_W-1:0]      cnt_q;
   logic                  in_ready_q;
   logic                  out_valid_q;

   // One add-3 correction cell per digit of the accumulator
   for (genvar g = 0; g < DIGITS; g++) begin : g_adj
      bcd_digit_adjust u_adj (
         .digit    (bcd_q[4*g +: 4]),
         .adjusted (bcd_adj[4*g +: 4])
      );
   end

   // Converter FSM: accept in IDLE, shift BIN_WIDTH times, hold the result in DONE until taken
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= IDLE;
         shift_q     <= '0;
         bcd_q       <= '0;
         overflow_q  <= 1'b0;
         cnt_q       <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  shift_q    <= bus.binary_in;
                  bcd_q      <= '0;
                  overflow_q <= 1'b0;
                  cnt_q      <= CNT_W'(BIN_WIDTH);
                  in_ready_q <= 1'b0;
                  state      <= SHIFT;
               end
            end
            SHIFT: begin
               bcd_q      <= {bcd_adj[BCD_W-2:0], shift_q[BIN_WIDTH-1]};
               shift_q    <= shift_q << 1;
               overflow_q <= overflow_q | (CAN_OVERFLOW & bcd_adj[BCD_W-1]);
               cnt_q      <= cnt_q - CNT_W'(1);
               if (cnt_q == CNT_W'(1)) begin
                  out_valid_q <= 1'b1;
                  state       <= DONE;
               end
            end
            DONE: begin
               if (bus.out_ready) begin
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  state       <= IDLE;
               end
            end
            default: begin
               out_valid_q <= 1'b0;
               in_ready_q  <= 1'b1;
               state       <= IDLE;
            end
         endcase
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.bcd_out   = bcd_q;
   assign bus.overflow  = overflow_q;

endmodule

// File: tb/tb_seq_binary_to_bcd.sv
// tb/tb_seq_binary_to_bcd.sv - self-checking bench for seq_binary_to_bcd over four parameter sets
module tb_seq_binary_to_bcd;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  vld;
   logic [3:0]  rdy;
   logic [63:0] bin;
   int          sel;
   int          checks = 0;
   int          errors = 0;

   logic        obs_ov;
   logic        obs_ir;
   logic        obs_of;
   logic [63:0] obs_bcd;

   always #5 clk = ~clk;

   seq_binary_to_bcd_if #(.BIN_WIDTH(8),  .DIGITS(3)) b0 ();
   seq_binary_to_bcd_if #(.BIN_WIDTH(16), .DIGITS(5)) b1 ();
   seq_binary_to_bcd_if #(.BIN_WIDTH(8),  .DIGITS(2)) b2 ();
   seq_binary_to_bcd_if #(.BIN_WIDTH(1),  .DIGITS(1)) b3 ();

   assign b0.in_valid = vld[0]; assign b0.binary_in = bin[7:0];  assign b0.out_ready = rdy[0];
   assign b1.in_valid = vld[1]; assign b1.binary_in = bin[15:0]; assign b1.out_ready = rdy[1];
   assign b2.in_valid = vld[2]; assign b2.binary_in = bin[7:0];  assign b2.out_ready = rdy[2];
   assign b3.in_valid = vld[3]; assign b3.binary_in = bin[0:0];  assign b3.out_ready = rdy[3];

   seq_binary_to_bcd #(.BIN_WIDTH(8),  .DIGITS(3)) u0 (.clk(clk), .rst_n(rst_n), .bus(b0));
   seq_binary_to_bcd #(.BIN_WIDTH(16), .DIGITS(5)) u1 (.clk(clk), .rst_n(rst_n), .bus(b1));
   seq_binary_to_bcd #(.BIN_WIDTH(8),  .DIGITS(2)) u2 (.clk(clk), .rst_n(rst_n), .bus(b2));
   seq_binary_to_bcd #(.BIN_WIDTH(1),  .DIGITS(1)) u3 (.clk(clk), .rst_n(rst_n), .bus(b3));

   // Observe the selected converter
   always_comb begin
      obs_ov = 1'b0; obs_ir = 1'b0; obs_of = 1'b0; obs_bcd = '0;
      case (sel)
         0: begin obs_ov = b0.out_valid; obs_ir = b0.in_ready; obs_of = b0.overflow; obs_bcd = 64'(b0.bcd_out); end
         1: begin obs_ov = b1.out_valid; obs_ir = b1.in_ready; obs_of = b1.overflow; obs_bcd = 64'(b1.bcd_out); end
         2: begin obs_ov = b2.out_valid; obs_ir = b2.in_ready; obs_of = b2.overflow; obs_bcd = 64'(b2.bcd_out); end
         default: begin obs_ov = b3.out_valid; obs_ir = b3.in_ready; obs_of = b3.overflow; obs_bcd = 64'(b3.bcd_out); end
      endcase
   end

   function automatic int width_of(input int s);
      case (s)
         0: return 8;
         1: return 16;
         2: return 8;
         default: return 1;
      endcase
   endfunction

   function automatic int digits_of(input int s);
      case (s)
         0: return 3;
         1: return 5;
         2: return 2;
         default: return 1;
      endcase
   endfunction

   // Reference: decimal digits of v (mod 10^d) packed four bits per digit
   function automatic logic [63:0] ref_bcd(input logic [63:0] v, input int d);
      logic [63:0] r = '0;
      logic [63:0] x = v;
      for (int k = 0; k < d; k++) begin
         r = r | ((x % 10) << (4 * k));
         x = x / 10;
      end
      return r;
   endfunction

   function automatic logic [63:0] pow10(input int d);
      logic [63:0] p = 64'd1;
      for (int k = 0; k < d; k++) p = p * 10;
      return p;
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Present one operand to the selected converter, wait for the result, check latency and value
   task automatic convert(input int s, input logic [63:0] v, input string tag);
      int lat;
      sel = s;
      @(negedge clk);
      vld[s] = 1'b1;
      bin    = v;
      @(negedge clk);
      vld[s] = 1'b0;
      lat    = 0;
      while (obs_ov !== 1'b1 && lat < 64) begin
         check({tag, " in_ready busy"}, 64'(obs_ir), 64'd0);
         @(negedge clk);
         lat++;
      end
      check({tag, " latency"}, 64'(lat), 64'(width_of(s)));
      check({tag, " in_ready done"}, 64'(obs_ir), 64'd0);
      check({tag, " bcd"}, obs_bcd, ref_bcd(v, digits_of(s)));
      check({tag, " overflow"}, 64'(obs_of), 64'(v >= pow10(digits_of(s))));
   endtask

   initial begin
      int n;
      rst_n = 1'b0;
      vld   = '0;
      rdy   = '1;
      bin   = '0;
      sel   = 0;

      // Reset state
      repeat (2) @(negedge clk);
      check("reset in_ready", 64'(obs_ir), 64'd1);
      check("reset out_valid", 64'(obs_ov), 64'd0);
      check("reset bcd", obs_bcd, 64'd0);
      check("reset overflow", 64'(obs_of), 64'd0);
      rst_n = 1'b1;

      // 255 on the default converter, then back to IDLE one cycle after delivery
      convert(0, 64'd255, "w8 255");
      check("w8 255 bcd literal", obs_bcd, 64'h255);
      @(negedge clk);
      check("w8 255 idle in_ready", 64'(obs_ir), 64'd1);
      check("w8 255 idle out_valid", 64'(obs_ov), 64'd0);

      // Full sweep back-to-back
      for (int v = 0; v < 256; v++) convert(0, 64'(v), "w8 sweep");

      // Wide operand, then random operands
      convert(1, 64'd65535, "w16 max");
      check("w16 max literal", obs_bcd, 64'h65535);
      for (int i = 0; i < 12; i++) convert(1, 64'($urandom_range(0, 65535)), "w16 rand");

      // Back-pressure: result must hold while out_ready is low; a new operand must be ignored
      sel    = 0;
      rdy[0] = 1'b0;
      @(negedge clk);
      vld[0] = 1'b1;
      bin    = 64'd200;
      @(negedge clk);
      bin    = 64'd111;
      n      = 0;
      while (obs_ov !== 1'b1 && n < 64) begin
         @(negedge clk);
         n++;
      end
      check("bp latency", 64'(n), 64'd8);
      for (int i = 0; i < 5; i++) begin
         check("bp bcd held", obs_bcd, 64'h200);
         check("bp out_valid held", 64'(obs_ov), 64'd1);
         check("bp in_ready low", 64'(obs_ir), 64'd0);
         if (i < 4) @(negedge clk);
      end
      rdy[0] = 1'b1;
      vld[0] = 1'b0;
      @(negedge clk);
      check("bp handshake in_ready", 64'(obs_ir), 64'd1);
      check("bp handshake out_valid", 64'(obs_ov), 64'd0);
      repeat (12) @(negedge clk);
      check("bp no stray result", 64'(obs_ov), 64'd0);

      // Too few digits: overflow set, cleared by the next in-range operand
      convert(2, 64'd123, "d2 123");
      check("d2 123 literal", obs_bcd, 64'h23);
      check("d2 123 overflow", 64'(obs_of), 64'd1);
      convert(2, 64'd99, "d2 99");
      check("d2 99 literal", obs_bcd, 64'h99);
      check("d2 99 overflow", 64'(obs_of), 64'd0);
      for (int i = 0; i < 10; i++) convert(2, 64'($urandom_range(0, 255)), "d2 rand");

      // Single-bit operand: one shift cycle
      convert(3, 64'd1, "w1 one");
      convert(3, 64'd0, "w1 zero");
      convert(3, 64'd1, "w1 one again");

      // Reset during SHIFT discards the conversion
      sel = 0;
      @(negedge clk);
      vld[0] = 1'b1;
      bin    = 64'd150;
      @(negedge clk);
      vld[0] = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      check("midreset in_ready", 64'(obs_ir), 64'd1);
      check("midreset out_valid", 64'(obs_ov), 64'd0);
      check("midreset bcd", obs_bcd, 64'd0);
      check("midreset overflow", 64'(obs_of), 64'd0);
      rst_n = 1'b1;
      convert(0, 64'd42, "after reset 42");
      check("after reset 42 literal", obs_bcd, 64'h042);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
